// File: rtl/rcosc_freq_monitor_if.sv
// Monitor control and result signals exchanged with the oscillator supervisor.
// The master drives enable, toggle and clear; the monitor (slave) returns results and the failover select.
interface rcosc_freq_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             osc_tgl;
    logic             fail_clr;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_count;
    logic             osc_ok;
    logic             osc_fail;
    logic             clk_sel;

    modport master (
        output en, osc_tgl, fail_clr,
        input  meas_valid, meas_count, osc_ok, osc_fail, clk_sel
    );

    modport slave (
        input  en, osc_tgl, fail_clr,
        output meas_valid, meas_count, osc_ok, osc_fail, clk_sel
    );
endinterface

// File: rtl/rcosc_freq_monitor.sv
// RC oscillator frequency supervisor: counts synchronised toggle edges over a CLK window,
// debounces in-band / out-of-band verdicts and drives a sticky failover clock select.
module rcosc_freq_monitor #(
    parameter int unsigned WINDOW     = 1024,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MIN_CNT    = 330,
    parameter int unsigned MAX_CNT    = 350,
    parameter int unsigned FAIL_LIMIT = 3,
    parameter int unsigned PASS_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rcosc_freq_monitor_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] EVAL    = 2'd3;

    localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned PS_W  = $clog2(PASS_LIMIT + 1);
    localparam int unsigned FS_W  = $clog2(FAIL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [1:0]       state, state_d;
    logic [WIN_W-1:0] cyc_cnt, cyc_cnt_d;
    logic [CNT_W-1:0] edge_cnt, edge_cnt_d;
    logic [PS_W-1:0]  pass_streak, pass_streak_d;
    logic [FS_W-1:0]  fail_streak, fail_streak_d;
    logic             sync1, sync2, hist;
    logic             meas_valid, meas_valid_d;
    logic [CNT_W-1:0] meas_count, meas_count_d;
    logic             osc_ok, osc_ok_d;
    logic             osc_fail, osc_fail_d;
    logic             clk_sel, clk_sel_d;
    logic             tgl_edge_c;
    logic             in_band_c;
    logic             fail_set_c;

    assign tgl_edge_c = sync2 ^ hist;
    assign in_band_c  = (edge_cnt >= CNT_W'(MIN_CNT)) && (edge_cnt <= CNT_W'(MAX_CNT));

    // Next-state, counters, streaks and registered outputs
    always_comb begin
        state_d       = state;
        cyc_cnt_d     = cyc_cnt;
        edge_cnt_d    = edge_cnt;
        pass_streak_d = pass_streak;
        fail_streak_d = fail_streak;
        meas_valid_d  = 1'b0;
        meas_count_d  = meas_count;
        osc_ok_d      = osc_ok;
        osc_fail_d    = osc_fail;
        clk_sel_d     = clk_sel;
        fail_set_c    = 1'b0;

        case (state)
            IDLE: begin
                cyc_cnt_d  = '0;
                edge_cnt_d = '0;
                if (bus.en) state_d = SETTLE;
            end
            SETTLE: begin
                if (!bus.en) begin
                    state_d   = IDLE;
                    cyc_cnt_d = '0;
                end else if (cyc_cnt == WIN_W'(2)) begin
                    state_d   = MEASURE;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt + WIN_W'(1);
                end
            end
            MEASURE: begin
                if (!bus.en) begin
                    state_d    = IDLE;
                    cyc_cnt_d  = '0;
                    edge_cnt_d = '0;
                end else begin
                    if (tgl_edge_c && (edge_cnt != CNT_SAT)) edge_cnt_d = edge_cnt + CNT_W'(1);
                    if (cyc_cnt == WIN_W'(WINDOW - 1)) begin
                        state_d   = EVAL;
                        cyc_cnt_d = '0;
                    end else begin
                        cyc_cnt_d = cyc_cnt + WIN_W'(1);
                    end
                end
            end
            default: begin
                // EVAL: publish count, debounce verdict; an edge arriving now is dropped
                meas_valid_d = 1'b1;
                meas_count_d = edge_cnt;
                edge_cnt_d   = '0;
                state_d      = bus.en ? MEASURE : IDLE;
                if (in_band_c) begin
                    fail_streak_d = '0;
                    if (pass_streak != PS_W'(PASS_LIMIT)) pass_streak_d = pass_streak + PS_W'(1);
                    if (pass_streak_d == PS_W'(PASS_LIMIT)) osc_ok_d = 1'b1;
                end else begin
                    pass_streak_d = '0;
                    osc_ok_d      = 1'b0;
                    if (fail_streak != FS_W'(FAIL_LIMIT)) fail_streak_d = fail_streak + FS_W'(1);
                    if (fail_streak_d == FS_W'(FAIL_LIMIT)) begin
                        fail_set_c = 1'b1;
                        osc_fail_d = 1'b1;
                        clk_sel_d  = 1'b1;
                    end
                end
            end
        endcase

        // A clear loses to a fail being set in the same cycle
        if (bus.fail_clr && !fail_set_c) begin
            osc_fail_d    = 1'b0;
            clk_sel_d     = 1'b0;
            fail_streak_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            edge_cnt    <= '0;
            pass_streak <= '0;
            fail_streak <= '0;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            hist        <= 1'b0;
            meas_valid  <= 1'b0;
            meas_count  <= '0;
            osc_ok      <= 1'b0;
            osc_fail    <= 1'b0;
            clk_sel     <= 1'b0;
        end else begin
            state       <= state_d;
            cyc_cnt     <= cyc_cnt_d;
            edge_cnt    <= edge_cnt_d;
            pass_streak <= pass_streak_d;
            fail_streak <= fail_streak_d;
            sync1       <= bus.osc_tgl;
            sync2       <= sync1;
            hist        <= sync2;
            meas_valid  <= meas_valid_d;
            meas_count  <= meas_count_d;
            osc_ok      <= osc_ok_d;
            osc_fail    <= osc_fail_d;
            clk_sel     <= clk_sel_d;
        end
    end

    assign bus.meas_valid = meas_valid;
    assign bus.meas_count = meas_count;
    assign bus.osc_ok     = osc_ok;
    assign bus.osc_fail   = osc_fail;
    assign bus.clk_sel    = clk_sel;
endmodule

// File: tb/tb_rcosc_freq_monitor.sv
// Directed bench for rcosc_freq_monitor: nominal, stuck, clear, streak, saturation, abort and reset scenarios.
`timescale 1ns/1ps
module tb_rcosc_freq_monitor;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    int   tgl_mode;   // 0 = hold, 1 = toggle every 3 CLK
    int   tgl_ph;
    int   n;

    rcosc_freq_monitor_if #(.CNT_W(16)) bus  ();
    rcosc_freq_monitor_if #(.CNT_W(8))  bus8 ();

    rcosc_freq_monitor #(
        .WINDOW(1024), .CNT_W(16), .MIN_CNT(330), .MAX_CNT(350), .FAIL_LIMIT(3), .PASS_LIMIT(4)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    rcosc_freq_monitor #(
        .WINDOW(1024), .CNT_W(8), .MIN_CNT(200), .MAX_CNT(250), .FAIL_LIMIT(1), .PASS_LIMIT(4)
    ) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator toggle models, changed away from the sampling edge
    always @(negedge clk) begin
        if (tgl_mode == 1) begin
            if (tgl_ph == 2) begin
                tgl_ph      = 0;
                bus.osc_tgl = ~bus.osc_tgl;
            end else begin
                tgl_ph = tgl_ph + 1;
            end
        end else begin
            tgl_ph = 0;
        end
        bus8.osc_tgl = ~bus8.osc_tgl;
    end

    // Returns posedges elapsed until meas_valid is seen; max+1 when it never arrives
    task automatic wait_valid(input int max, output int cycles);
        bit got;
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles <= max) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            got = (bus.meas_valid === 1'b1);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.en = 1'b0;  bus.fail_clr = 1'b0;  bus.osc_tgl = 1'b0;
        bus8.en = 1'b0; bus8.fail_clr = 1'b0; bus8.osc_tgl = 1'b0;
        tgl_mode = 0; tgl_ph = 0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.meas_valid, bus.meas_count, bus.osc_ok, bus.osc_fail, bus.clk_sel} !== 20'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want 0",
                     {bus.meas_valid, bus.meas_count, bus.osc_ok, bus.osc_fail, bus.clk_sel});
        end
        compared++;
        if (dut.state !== 2'd0) begin
            mismatched++; $display("FAIL reset_state: got %0d want 0", dut.state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturate;
        bus8.en = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (bus8.meas_valid !== 1'b1 && n <= 1100);
        compared++;
        if (n != 1029) begin mismatched++; $display("FAIL sat_latency: got %0d want 1029", n); end
        compared++;
        if (bus8.meas_count !== 8'd255) begin
            mismatched++; $display("FAIL sat_count: got %0d want 255", bus8.meas_count);
        end
        compared++;
        if ({bus8.osc_fail, bus8.clk_sel, bus8.osc_ok} !== 3'b110) begin
            mismatched++; $display("FAIL sat_verdict: got %b want 110", {bus8.osc_fail, bus8.clk_sel, bus8.osc_ok});
        end
        bus8.en = 1'b0;
        @(negedge clk);
        compared++;
        if (bus8.meas_valid !== 1'b0) begin
            mismatched++; $display("FAIL valid_pulse_width: got %b want 0", bus8.meas_valid);
        end
    endtask

    task automatic test_nominal;
        tgl_mode = 1;
        bus.en = 1'b1;
        wait_valid(1100, n);
        compared++;
        if (n - 1 != 1028) begin mismatched++; $display("FAIL first_valid_cycle: got %0d want 1028", n - 1); end
        compared++;
        if (bus.meas_count < 16'd340 || bus.meas_count > 16'd342) begin
            mismatched++; $display("FAIL nominal_count: got %0d want 340..342", bus.meas_count);
        end
        for (int w = 2; w <= 4; w++) begin
            compared++;
            if (bus.osc_ok !== 1'b0) begin mismatched++; $display("FAIL ok_early w%0d: got %b want 0", w - 1, bus.osc_ok); end
            wait_valid(1100, n);
            compared++;
            if (n != 1025) begin mismatched++; $display("FAIL window_period w%0d: got %0d want 1025", w, n); end
        end
        compared++;
        if ({bus.osc_ok, bus.osc_fail, bus.clk_sel} !== 3'b100) begin
            mismatched++; $display("FAIL nominal_flags: got %b want 100", {bus.osc_ok, bus.osc_fail, bus.clk_sel});
        end
    endtask

    task automatic test_stuck;
        tgl_mode = 0;
        wait_valid(1100, n);
        compared++;
        if (bus.osc_ok !== 1'b0 || bus.meas_count >= 16'd330) begin
            mismatched++; $display("FAIL stuck_w1: got ok=%b count=%0d want ok=0 count<330", bus.osc_ok, bus.meas_count);
        end
        wait_valid(1100, n);
        compared++;
        if (bus.meas_count !== 16'd0 || bus.osc_fail !== 1'b0) begin
            mismatched++; $display("FAIL stuck_w2: got count=%0d fail=%b want 0/0", bus.meas_count, bus.osc_fail);
        end
        wait_valid(1100, n);
        compared++;
        if ({bus.osc_fail, bus.clk_sel} !== 2'b11) begin
            mismatched++; $display("FAIL stuck_w3_fail: got %b want 11", {bus.osc_fail, bus.clk_sel});
        end
        tgl_mode = 1;
        wait_valid(1100, n);
        compared++;
        if ({bus.osc_fail, bus.clk_sel, bus.osc_ok} !== 3'b110) begin
            mismatched++; $display("FAIL sticky_after_restore: got %b want 110", {bus.osc_fail, bus.clk_sel, bus.osc_ok});
        end
    endtask

    task automatic test_fail_clr;
        repeat (10) @(negedge clk);
        bus.fail_clr = 1'b1;
        @(negedge clk);
        bus.fail_clr = 1'b0;
        compared++;
        if ({bus.osc_fail, bus.clk_sel} !== 2'b00) begin
            mismatched++; $display("FAIL fail_clr: got %b want 00", {bus.osc_fail, bus.clk_sel});
        end
        wait_valid(1100, n);
        compared++;
        if (n != 1014) begin mismatched++; $display("FAIL clr_no_interrupt: got %0d want 1014", n); end
    endtask

    task automatic test_streak_reset;
        int pat [5] = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            tgl_mode = pat[i];
            wait_valid(1100, n);
            compared++;
            if (bus.osc_fail !== 1'b0 || n != 1025) begin
                mismatched++; $display("FAIL streak_w%0d: got fail=%b period=%0d want 0/1025", i, bus.osc_fail, n);
            end
        end
    endtask

    task automatic test_abort;
        tgl_mode = 1;
        repeat (500) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        compared++;
        if (dut.state !== 2'd0) begin mismatched++; $display("FAIL abort_idle: got %0d want 0", dut.state); end
        wait_valid(1100, n);
        compared++;
        if (n != 1101) begin mismatched++; $display("FAIL abort_no_valid: got valid after %0d want none", n); end
        bus.en = 1'b1;
        wait_valid(1100, n);
        compared++;
        if (n - 1 != 1028) begin mismatched++; $display("FAIL reenable_latency: got %0d want 1028", n - 1); end
    endtask

    task automatic test_reset_mid;
        tgl_mode = 0;
        repeat (3) wait_valid(1100, n);
        compared++;
        if (bus.osc_fail !== 1'b1) begin mismatched++; $display("FAIL pre_reset_fail: got %b want 1", bus.osc_fail); end
        repeat (200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if ({bus.meas_valid, bus.meas_count, bus.osc_ok, bus.osc_fail, bus.clk_sel, dut.state} !== 22'h0) begin
            mismatched++;
            $display("FAIL mid_reset: got fail=%b sel=%b state=%0d count=%0d want all 0",
                     bus.osc_fail, bus.clk_sel, dut.state, bus.meas_count);
        end
    endtask

    task automatic test_clr_vs_set;
        wait_valid(1100, n);
        compared++;
        if (n - 1 != 1028) begin mismatched++; $display("FAIL post_reset_latency: got %0d want 1028", n - 1); end
        wait_valid(1100, n);
        repeat (1024) @(negedge clk);
        bus.fail_clr = 1'b1;
        @(negedge clk);
        bus.fail_clr = 1'b0;
        compared++;
        if ({bus.meas_valid, bus.osc_fail, bus.clk_sel} !== 3'b111) begin
            mismatched++; $display("FAIL clr_vs_set: got %b want 111", {bus.meas_valid, bus.osc_fail, bus.clk_sel});
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset;
        test_saturate;
        test_nominal;
        test_stuck;
        test_fail_clr;
        test_streak_reset;
        test_abort;
        test_reset_mid;
        test_clr_vs_set;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
